// File: rtl/smem_result_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// smem_result_buffer: gathers per-read SMEM entries, sizes and return codes for one batch,
// then drains them as header/data beats on a 512-bit bus with a fixed two-stage output pipeline.
module smem_result_buffer #(
  parameter int MAX_READ       = 512,
  parameter int READ_NUM_WIDTH = 9,
  parameter int SLOTS          = 20,
  parameter int ENTRY_W        = 113,
  parameter int LANES          = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic [READ_NUM_WIDTH:0]   batch_size,
  input  logic                      wr_en,
  input  logic [READ_NUM_WIDTH-1:0] wr_read_num,
  input  logic [6:0]                wr_addr,
  input  logic [ENTRY_W-1:0]        wr_data,
  input  logic                      size_valid,
  input  logic [6:0]                size,
  input  logic [READ_NUM_WIDTH-1:0] size_read_num,
  input  logic                      ret_valid,
  input  logic [6:0]                ret,
  input  logic [READ_NUM_WIDTH-1:0] ret_read_num,
  output logic                      out_request,
  input  logic                      out_permit,
  output logic [511:0]              out_data,
  output logic                      out_valid,
  output logic                      out_finish,
  output logic                      err_overflow
);
  localparam int DEPTH  = MAX_READ * SLOTS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LANE_W = 512 / LANES;
  localparam int LSH    = $clog2(LANES);
  localparam logic [READ_NUM_WIDTH:0] MAX_READ_V = (READ_NUM_WIDTH+1)'(MAX_READ);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    DATA   = 3'd2,
    GAP    = 3'd3,
    FINISH = 3'd4
  } state_t;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [6:0] size_tab [MAX_READ];
  logic [6:0] ret_tab  [MAX_READ];

  logic                      wr_en_q;
  logic [READ_NUM_WIDTH-1:0] wr_num_q;
  logic [6:0]                wr_addr_q;
  logic [ENTRY_W-1:0]        wr_data_q;
  logic [ADDR_W-1:0]         wr_ram_addr;
  logic                      wr_ok, size_num_ok, ret_num_ok;
  logic [6:0]                size_clip;

  logic [READ_NUM_WIDTH:0]   done_count;
  logic                      all_done;

  state_t                    state, state_n;
  logic [READ_NUM_WIDTH-1:0] ptr, ptr_n;
  logic [READ_NUM_WIDTH:0]   ptr_inc;
  logic [6:0]                beat_cnt, beat_n, cur_size, cur_size_n, last_beat;
  logic                      advance, issue_hdr, issue_data;
  logic [ADDR_W-1:0]         base;
  logic [LANES-1:0]          lane_live;
  logic [LANES-1:0][ADDR_W-1:0] rd_addr;

  logic                      hdr_q, data_q, fin_q;
  logic [LANES-1:0]          live_q;
  logic [READ_NUM_WIDTH-1:0] hdr_ptr_q;
  logic [6:0]                hdr_size_q, hdr_ret_q;
  logic [ENTRY_W-1:0]        rd_data [LANES];
  logic [511:0]              beat;

  assign wr_ok       = (wr_addr < 7'(SLOTS)) && ({1'b0, wr_read_num} < MAX_READ_V);
  assign size_num_ok = {1'b0, size_read_num} < MAX_READ_V;
  assign ret_num_ok  = {1'b0, ret_read_num} < MAX_READ_V;
  assign size_clip   = (size > 7'(SLOTS)) ? 7'(SLOTS) : size;
  assign wr_ram_addr = ADDR_W'(wr_num_q) * ADDR_W'(SLOTS) + ADDR_W'(wr_addr_q);

  // Inputs presented while stall is high are not captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q      <= 1'b0;
      err_overflow <= 1'b0;
      done_count   <= '0;
      all_done     <= 1'b0;
      out_request  <= 1'b0;
    end else if (!stall) begin
      wr_en_q   <= wr_en && wr_ok;
      wr_num_q  <= wr_read_num;
      wr_addr_q <= wr_addr;
      wr_data_q <= wr_data;
      if ((wr_en && !wr_ok) || (size_valid && size > 7'(SLOTS)))
        err_overflow <= 1'b1;
      if (size_valid)
        done_count <= done_count + 1'b1;
      all_done    <= (done_count == batch_size) && (batch_size != '0);
      out_request <= all_done;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !stall) begin
      if (wr_en_q)
        mem[wr_ram_addr] <= wr_data_q;
      if (size_valid && size_num_ok)
        size_tab[size_read_num] <= size_clip;
      if (ret_valid && ret_num_ok)
        ret_tab[ret_read_num] <= ret;
    end
  end

  assign advance   = out_permit && !stall;
  assign ptr_inc   = {1'b0, ptr} + {{READ_NUM_WIDTH{1'b0}}, 1'b1};
  assign last_beat = (cur_size - 7'd1) >> LSH;
  assign base      = ADDR_W'(ptr) * ADDR_W'(SLOTS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      beat_cnt <= '0;
      cur_size <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      beat_cnt <= beat_n;
      cur_size <= cur_size_n;
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    beat_n     = beat_cnt;
    cur_size_n = cur_size;
    issue_hdr  = 1'b0;
    issue_data = 1'b0;
    if (advance) begin
      case (state)
        IDLE:   if (all_done) state_n = HEADER;
        HEADER: begin
          issue_hdr  = 1'b1;
          cur_size_n = size_tab[ptr];
          beat_n     = '0;
          state_n    = (size_tab[ptr] != 7'd0) ? DATA : GAP;
        end
        DATA: begin
          issue_data = 1'b1;
          if (beat_cnt == last_beat) state_n = GAP;
          else                       beat_n  = beat_cnt + 7'd1;
        end
        GAP: begin
          ptr_n   = ptr_inc[READ_NUM_WIDTH-1:0];
          state_n = (ptr_inc < batch_size) ? HEADER : FINISH;
        end
        FINISH: state_n = FINISH;
        default: state_n = IDLE;
      endcase
    end
  end

  // Lanes past the read's size are masked; their address is parked at 0 to stay in range.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0] lane_idx;
    assign lane_idx     = 8'(beat_cnt) * 8'(LANES) + 8'(i);
    assign lane_live[i] = issue_data && (lane_idx < {1'b0, cur_size});
    assign rd_addr[i]   = lane_live[i] ? (base + ADDR_W'(lane_idx)) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_q  <= 1'b0;
      data_q <= 1'b0;
      fin_q  <= 1'b0;
      live_q <= '0;
    end else if (!stall) begin
      hdr_q  <= issue_hdr;
      data_q <= issue_data;
      fin_q  <= (state == FINISH);
      live_q <= lane_live;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      hdr_ptr_q  <= ptr;
      hdr_size_q <= size_tab[ptr];
      hdr_ret_q  <= ret_tab[ptr];
      for (int i = 0; i < LANES; i++)
        rd_data[i] <= mem[rd_addr[i]];
    end
  end

  always_comb begin
    beat = '0;
    if (hdr_q) begin
      beat[READ_NUM_WIDTH-1:0] = hdr_ptr_q;
      beat[70:64]              = hdr_size_q;
      beat[134:128]            = hdr_ret_q;
    end
    for (int i = 0; i < LANES; i++)
      if (data_q && live_q[i])
        beat[i*LANE_W +: ENTRY_W] = rd_data[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_finish <= 1'b0;
      out_data   <= '0;
    end else if (!stall) begin
      out_valid  <= hdr_q || data_q;
      out_finish <= fin_q;
      out_data   <= beat;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_smem_result_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// Randomized bench for smem_result_buffer: expected beat streams are built from the batch contents.
module tb_smem_result_buffer;
  localparam int MAX_READ = 512;
  localparam int RNW      = 9;
  localparam int SLOTS    = 20;
  localparam int ENTRY_W  = 113;
  localparam int LANES    = 2;
  localparam int NR       = 8;

  logic clk = 1'b0;
  logic reset, stall, wr_en, size_valid, ret_valid, out_permit;
  logic [RNW:0]        batch_size;
  logic [RNW-1:0]      wr_read_num, size_read_num, ret_read_num;
  logic [6:0]          wr_addr, size, ret;
  logic [ENTRY_W-1:0]  wr_data;
  logic                out_request, out_valid, out_finish, err_overflow;
  logic [511:0]        out_data;

  smem_result_buffer #(
    .MAX_READ(MAX_READ), .READ_NUM_WIDTH(RNW), .SLOTS(SLOTS), .ENTRY_W(ENTRY_W), .LANES(LANES)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .batch_size(batch_size),
    .wr_en(wr_en), .wr_read_num(wr_read_num), .wr_addr(wr_addr), .wr_data(wr_data),
    .size_valid(size_valid), .size(size), .size_read_num(size_read_num),
    .ret_valid(ret_valid), .ret(ret), .ret_read_num(ret_read_num),
    .out_request(out_request), .out_permit(out_permit), .out_data(out_data),
    .out_valid(out_valid), .out_finish(out_finish), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference contents of the current batch
  logic [ENTRY_W-1:0] m_ent [NR][SLOTS];
  int                 m_size [NR];
  logic [6:0]         m_ret [NR];
  logic [511:0]       exp_q[$];
  logic [511:0]       got_q[$];

  // Output monitor: one beat per non-stalled edge with out_valid; frozen outputs during stall.
  logic         adv_edge, frz_edge, prev_valid;
  logic [511:0] prev_data;
  always @(posedge clk) begin
    adv_edge <= !stall && !reset;
    frz_edge <= stall && !reset;
  end
  always @(negedge clk) begin
    if (adv_edge && out_valid) got_q.push_back(out_data);
    if (frz_edge) begin
      check_value("freeze_data", out_data, prev_data);
      check_value("freeze_valid", {511'd0, out_valid}, {511'd0, prev_valid});
    end
    prev_data  <= out_data;
    prev_valid <= out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; out_permit = 1'b0;
    wr_en = 1'b0; size_valid = 1'b0; ret_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  function automatic int clip(input int s);
    return (s > SLOTS) ? SLOTS : s;
  endfunction

  function automatic logic [ENTRY_W-1:0] rnd_entry();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[ENTRY_W-1:0];
  endfunction

  task automatic fill_random(input int nb, input int max_size);
    for (int r = 0; r < nb; r++) begin
      m_size[r] = $urandom_range(0, max_size);
      m_ret[r]  = 7'($urandom);
      for (int s = 0; s < SLOTS; s++) m_ent[r][s] = rnd_entry();
    end
  endtask

  task automatic build_exp(input int nb);
    logic [511:0] b;
    int s;
    exp_q.delete();
    for (int r = 0; r < nb; r++) begin
      s = clip(m_size[r]);
      b = '0;
      b[RNW-1:0]   = RNW'(r);
      b[70:64]     = 7'(s);
      b[134:128]   = m_ret[r];
      exp_q.push_back(b);
      for (int k = 0; k < s; k += LANES) begin
        b = '0;
        for (int l = 0; l < LANES; l++)
          if (k + l < s) b[l*(512/LANES) +: ENTRY_W] = m_ent[r][k+l];
        exp_q.push_back(b);
      end
    end
  endtask

  // Junk write targets wr_addr == SLOTS of read 0, which would alias read 1 slot 0 if kept.
  task automatic load_batch(input int nb, input bit fresh, input bit junk);
    out_permit = 1'b0;
    batch_size = (RNW+1)'(nb);
    if (fresh)
      for (int r = 0; r < nb; r++)
        for (int s = 0; s < clip(m_size[r]); s++) begin
          wr_en = 1'b1; wr_read_num = RNW'(r); wr_addr = 7'(s); wr_data = m_ent[r][s];
          tick();
        end
    if (junk) begin
      wr_en = 1'b1; wr_read_num = '0; wr_addr = 7'(SLOTS); wr_data = rnd_entry();
      tick();
    end
    wr_en = 1'b0;
    for (int r = 0; r < nb; r++) begin
      if (r == nb - 1) check_value("request_early", {511'd0, out_request}, 512'd0);
      size_valid = 1'b1; size = 7'(m_size[r]); size_read_num = RNW'(r);
      ret_valid  = 1'b1; ret  = m_ret[r];      ret_read_num  = RNW'(r);
      tick();
    end
    size_valid = 1'b0; ret_valid = 1'b0;
    tick(); tick(); tick();
    check_value("request", {511'd0, out_request}, 512'd1);
  endtask

  // pmode: 0 permit held, 1 toggled, 2 random.  smode: 0 none, 1 four-cycle burst mid-data, 2 random.
  task automatic drain(input int pmode, input int smode, input string tag);
    int cyc, burst;
    bit burst_done;
    int n;
    got_q.delete();
    cyc = 0; burst = 0; burst_done = 1'b0;
    while (!out_finish && cyc < 3000) begin
      case (pmode)
        0:       out_permit = 1'b1;
        1:       out_permit = cyc[0];
        default: out_permit = ($urandom_range(0, 2) != 0);
      endcase
      case (smode)
        1: begin
          if (!burst_done && got_q.size() >= 2) begin burst = 4; burst_done = 1'b1; end
          stall = (burst > 0);
          if (burst > 0) burst--;
        end
        2:       stall = ($urandom_range(0, 3) == 0);
        default: stall = 1'b0;
      endcase
      tick();
      cyc++;
    end
    stall = 1'b0;
    check_value({tag, "_finish"}, {511'd0, out_finish}, 512'd1);
    tick(); tick();
    check_value({tag, "_beats"}, 512'(got_q.size()), 512'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check_value($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    check_value({tag, "_finish_hold"}, {510'd0, out_finish, out_valid}, 512'd2);
    out_permit = 1'b0;
  endtask

  initial begin
    int nb, cyc;
    reset = 1'b1; stall = 1'b0; out_permit = 1'b0; batch_size = '0;
    wr_en = 1'b0; wr_read_num = '0; wr_addr = '0; wr_data = '0;
    size_valid = 1'b0; size = '0; size_read_num = '0;
    ret_valid = 1'b0; ret = '0; ret_read_num = '0;
    tick(); tick();
    check_value("rst_request", {511'd0, out_request}, 512'd0);
    check_value("rst_valid", {511'd0, out_valid}, 512'd0);
    check_value("rst_finish", {511'd0, out_finish}, 512'd0);
    check_value("rst_overflow", {511'd0, err_overflow}, 512'd0);
    check_value("rst_data", out_data, 512'd0);
    reset = 1'b0;
    tick();

    // One read, three entries, ret 5
    fill_random(1, 0);
    m_size[0] = 3; m_ret[0] = 7'd5;
    load_batch(1, 1'b1, 1'b0); build_exp(1); drain(0, 0, "basic");

    // Empty read followed by a one-entry read
    do_reset();
    fill_random(2, 0);
    m_size[1] = 1;
    load_batch(2, 1'b1, 1'b0); build_exp(2);
    check_value("zero_exp_len", 512'(exp_q.size()), 512'd3);
    drain(0, 0, "zero_size");

    // Stall burst in the middle of the data phase
    do_reset();
    fill_random(1, 0);
    m_size[0] = 11;
    load_batch(1, 1'b1, 1'b0); build_exp(1); drain(0, 1, "stall");

    // Permit toggled every other cycle
    do_reset();
    fill_random(3, SLOTS);
    load_batch(3, 1'b1, 1'b0); build_exp(3); drain(1, 0, "toggle");

    // Out-of-range write and oversized size
    do_reset();
    check_value("ovf_clear", {511'd0, err_overflow}, 512'd0);
    fill_random(2, 0);
    m_size[0] = SLOTS + 3; m_size[1] = 2;
    load_batch(2, 1'b1, 1'b1);
    check_value("ovf_set", {511'd0, err_overflow}, 512'd1);
    build_exp(2); drain(0, 0, "overflow");
    check_value("ovf_sticky", {511'd0, err_overflow}, 512'd1);
    do_reset();
    check_value("ovf_reset", {511'd0, err_overflow}, 512'd0);

    // Reset mid-drain, then re-run from retained RAM contents
    fill_random(1, 0);
    m_size[0] = 7;
    load_batch(1, 1'b1, 1'b0); build_exp(1);
    got_q.delete();
    out_permit = 1'b1;
    cyc = 0;
    while (got_q.size() < 2 && cyc < 200) begin tick(); cyc++; end
    check_value("abort_reached", 512'(cyc < 200), 512'd1);
    reset = 1'b1;
    tick();
    check_value("abort_outputs", {out_data, out_valid, out_finish, out_request, err_overflow}, 516'd0);
    reset = 1'b0; out_permit = 1'b0;
    tick();
    check_value("abort_after", {510'd0, out_valid, out_finish}, 512'd0);
    load_batch(1, 1'b0, 1'b0);
    drain(0, 0, "rerun");

    // Random batches with random permit and stall
    for (int it = 0; it < 4; it++) begin
      do_reset();
      nb = $urandom_range(1, 6);
      fill_random(nb, SLOTS);
      load_batch(nb, 1'b1, 1'b0); build_exp(nb);
      drain(2, 2, $sformatf("rand%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
